// File: rtl/calc_sequencer.sv
// calc_sequencer: fetch/decode/execute controller for the calculator datapath.
// Fetches 16-bit instructions from memory at pc and decodes opcode [15:13].
// It then drives the regfile, ALU, memory and mux controls until one of three
// things happens: HALT, an illegal opcode, or the instruction watchdog expires.
// Control outputs are a decode of the registered state and instruction.
// The status outputs (busy, done, flags, pc, instr_count) come straight from flops.
module calc_sequencer #(
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter logic [15:0] MAX_INSTR  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] mem_q,
    input  logic        alu_neg,
    output logic [15:0] pc,
    output logic        addr_sel,
    output logic        mem_we,
    output logic [3:0]  rf_ra1,
    output logic [3:0]  rf_ra2,
    output logic [3:0]  rf_wa,
    output logic        rf_we,
    output logic [2:0]  alu_mode,
    output logic        wd_sel,
    output logic        busy,
    output logic        done,
    output logic        neg_flag,
    output logic        illegal,
    output logic        timeout,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_LD_ADDR = 3'd4,
        ST_LD_WB   = 3'd5,
        ST_STORE   = 3'd6
    } state_t;

    localparam logic [2:0] OP_LD      = 3'b100;
    localparam logic [2:0] OP_ST      = 3'b101;
    localparam logic [2:0] OP_ILLEGAL = 3'b110;
    localparam logic [2:0] OP_HALT    = 3'b111;
    localparam logic [2:0] ALU_IDLE   = 3'b100;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        neg_q, neg_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;

    logic [2:0]  fetched_op_s;
    logic [15:0] count_inc_s;
    logic        watchdog_hit_s;
    logic [3:0]  rd_s;
    logic [3:0]  rb_s;
    logic        mem_we_s;
    logic        rf_we_s;

    // The opcode comes straight from mem_q while decoding, because IR is loaded on that same edge.
    assign fetched_op_s   = mem_q[15:13];
    assign count_inc_s    = count_q + 16'd1;
    assign watchdog_hit_s = (count_inc_s == MAX_INSTR);
    assign rd_s           = ir_q[11:8];
    assign rb_s           = ir_q[3:0];

    // State and status register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= START_ADDR;
            ir_q      <= 16'h0000;
            count_q   <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            neg_q     <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            neg_q     <= neg_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: sequencing, pc/IR updates, instruction counting and run-end flags.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        neg_d     = neg_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = START_ADDR;
                    count_d   = 16'h0000;
                    busy_d    = 1'b1;
                    neg_d     = 1'b0;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d = mem_q;
                pc_d = pc_q + 16'd1;
                case (fetched_op_s)
                    OP_LD:      state_d = ST_LD_ADDR;
                    OP_ST:      state_d = ST_STORE;
                    OP_ILLEGAL: begin
                        state_d   = ST_IDLE;
                        illegal_d = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                    OP_HALT: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default:    state_d = ST_EXEC;
                endcase
            end
            ST_EXEC, ST_LD_WB, ST_STORE: begin
                // Last cycle of a counted instruction; the watchdog may end the run here.
                count_d = count_inc_s;
                if (state_q == ST_EXEC) begin
                    neg_d = alu_neg;
                end else begin
                    neg_d = neg_q;
                end
                if (watchdog_hit_s) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LD_ADDR: begin
                state_d = ST_LD_WB;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Datapath control decode from the current state and instruction register.
    always_comb begin
        addr_sel = 1'b1;
        alu_mode = ALU_IDLE;
        wd_sel   = 1'b0;
        rf_ra1   = 4'd0;
        rf_ra2   = 4'd0;
        rf_wa    = 4'd0;
        mem_we_s = 1'b0;
        rf_we_s  = 1'b0;
        case (state_q)
            ST_EXEC: begin
                rf_ra1   = rd_s;
                rf_ra2   = rb_s;
                rf_wa    = rd_s;
                alu_mode = ir_q[15:13];
                rf_we_s  = (rd_s != 4'd0);
            end
            ST_LD_ADDR: begin
                rf_ra2   = rb_s;
                addr_sel = 1'b0;
            end
            ST_LD_WB: begin
                rf_wa   = rd_s;
                wd_sel  = 1'b1;
                rf_we_s = (rd_s != 4'd0);
            end
            ST_STORE: begin
                rf_ra1   = rd_s;
                rf_ra2   = rb_s;
                addr_sel = 1'b0;
                mem_we_s = 1'b1;
            end
            default: begin
                addr_sel = 1'b1;
            end
        endcase
    end

    // Write enables are gated by reset so an in-flight instruction cannot disturb state.
    assign mem_we      = mem_we_s & reset;
    assign rf_we       = rf_we_s & reset;

    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign neg_flag    = neg_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer with a small behavioural datapath:
// a 16x16 regfile, a 256-word registered memory, an ALU and the address/write-data muxes.
// The watchdog limit is set to 4 so the timeout run stays short.
module tb_calc_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] mem_q;
    logic        alu_neg;
    logic [15:0] pc;
    logic        addr_sel;
    logic        mem_we;
    logic [3:0]  rf_ra1;
    logic [3:0]  rf_ra2;
    logic [3:0]  rf_wa;
    logic        rf_we;
    logic [2:0]  alu_mode;
    logic        wd_sel;
    logic        busy;
    logic        done;
    logic        neg_flag;
    logic        illegal;
    logic        timeout;
    logic [15:0] instr_count;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    calc_sequencer #(.START_ADDR(16'h0000), .MAX_INSTR(16'd4)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_q(mem_q), .alu_neg(alu_neg),
        .pc(pc), .addr_sel(addr_sel), .mem_we(mem_we), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_wa(rf_wa), .rf_we(rf_we), .alu_mode(alu_mode), .wd_sel(wd_sel), .busy(busy),
        .done(done), .neg_flag(neg_flag), .illegal(illegal), .timeout(timeout),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model
    logic [15:0] rf  [0:15];
    logic [15:0] mem [0:255];
    logic [15:0] rd1, rd2, alu_res, mem_addr, wd;
    logic        pre_en;
    logic        pre_reg;
    logic [7:0]  pre_a;
    logic [15:0] pre_d;

    always_comb begin
        rd1 = (rf_ra1 == 4'd0) ? 16'h0000 : rf[rf_ra1];
        rd2 = (rf_ra2 == 4'd0) ? 16'h0000 : rf[rf_ra2];
        alu_neg = 1'b0;
        case (alu_mode)
            3'd0: alu_res = rd1 + rd2;
            3'd1: begin
                alu_neg = (rd1 < rd2);
                alu_res = (rd1 < rd2) ? (rd2 - rd1) : (rd1 - rd2);
            end
            3'd2: alu_res = rd1 * rd2;
            3'd3: alu_res = (rd2 == 16'h0000) ? 16'h0000 : (rd1 / rd2);
            default: alu_res = 16'h0000;
        endcase
        mem_addr = addr_sel ? pc : rd2;
        wd = wd_sel ? mem_q : alu_res;
    end

    always @(posedge clk) begin
        if (pre_en) begin
            if (pre_reg) rf[pre_a[3:0]] <= pre_d;
            else         mem[pre_a]     <= pre_d;
        end
        if (mem_we) mem[mem_addr[7:0]] <= rd1;
        if (rf_we)  rf[rf_wa] <= wd;
        mem_q <= mem[mem_addr[7:0]];
    end

    always @(negedge clk) begin
        if (mem_we || rf_we) we_count <= we_count + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic is_reg, input logic [7:0] a, input logic [15:0] d);
        pre_en  = 1'b1;
        pre_reg = is_reg;
        pre_a   = a;
        pre_d   = d;
        tick;
        pre_en  = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick;
            n++;
        end
        check(tag, {15'd0, done}, 16'd1);
    endtask

    int we_snap;

    initial begin
        reset = 1'b0; start = 1'b0; pre_en = 1'b0; pre_reg = 1'b0;
        pre_a = 8'd0; pre_d = 16'h0000;
        tick; tick; tick;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_pc", pc, 16'h0000);
        check("rst_count", instr_count, 16'd0);
        check("rst_alu_mode", {13'd0, alu_mode}, 16'd4);
        check("rst_addr_sel", {15'd0, addr_sel}, 16'd1);
        reset = 1'b1;

        // ADD r1,r2 then HALT
        poke(1'b0, 8'h00, 16'h0102); poke(1'b0, 8'h01, 16'hE000);
        poke(1'b1, 8'h01, 16'd5);    poke(1'b1, 8'h02, 16'd7);
        pulse_start;
        check("add_fetch_busy", {15'd0, busy}, 16'd1);
        check("add_fetch_pc", pc, 16'h0000);
        tick; tick;
        check("add_exec_mode", {13'd0, alu_mode}, 16'd0);
        check("add_exec_we", {15'd0, rf_we}, 16'd1);
        check("add_exec_wa", {12'd0, rf_wa}, 16'd1);
        tick;
        check("add_r1", rf[1], 16'd12);
        tick; tick;
        check("add_done", {15'd0, done}, 16'd1);
        check("add_busy_end", {15'd0, busy}, 16'd0);
        check("add_count", instr_count, 16'd1);
        check("add_neg", {15'd0, neg_flag}, 16'd0);
        check("add_pc_end", pc, 16'd2);
        tick;
        check("add_done_pulse", {15'd0, done}, 16'd0);

        // SUB r1,r2 with r1<r2
        poke(1'b0, 8'h00, 16'h2102);
        poke(1'b1, 8'h01, 16'd3); poke(1'b1, 8'h02, 16'd9);
        pulse_start;
        tick; tick;
        check("sub_exec_mode", {13'd0, alu_mode}, 16'd1);
        tick;
        check("sub_r1", rf[1], 16'd6);
        check("sub_neg", {15'd0, neg_flag}, 16'd1);
        wait_done("sub_done", 20);
        check("sub_count", instr_count, 16'd1);

        // ST r3,[r4]; LD r5,[r4]; HALT
        poke(1'b0, 8'h00, 16'hA304); poke(1'b0, 8'h01, 16'h8504); poke(1'b0, 8'h02, 16'hE000);
        poke(1'b1, 8'h03, 16'hBEEF); poke(1'b1, 8'h04, 16'h0040);
        poke(1'b1, 8'h05, 16'h0000); poke(1'b0, 8'h40, 16'h0000);
        pulse_start;
        check("st_neg_cleared", {15'd0, neg_flag}, 16'd0);
        tick; tick;
        check("st_mem_we", {15'd0, mem_we}, 16'd1);
        check("st_addr_sel", {15'd0, addr_sel}, 16'd0);
        tick;
        check("st_mem40", mem[8'h40], 16'hBEEF);
        tick; tick;
        check("ld_addr_sel", {15'd0, addr_sel}, 16'd0);
        check("ld_addr_memwe", {15'd0, mem_we}, 16'd0);
        tick;
        check("ld_wb_wdsel", {15'd0, wd_sel}, 16'd1);
        check("ld_wb_wa", {12'd0, rf_wa}, 16'd5);
        tick;
        check("ld_r5", rf[5], 16'hBEEF);
        wait_done("ldst_done", 20);
        check("ldst_count", instr_count, 16'd2);

        // Illegal opcode
        poke(1'b0, 8'h00, 16'hC000);
        we_snap = we_count;
        pulse_start;
        tick; tick;
        check("ill_flag", {15'd0, illegal}, 16'd1);
        check("ill_done", {15'd0, done}, 16'd1);
        check("ill_busy", {15'd0, busy}, 16'd0);
        check("ill_count", instr_count, 16'd0);
        check("ill_no_we", we_count[15:0], we_snap[15:0]);

        // Reset during ST
        poke(1'b0, 8'h00, 16'hA304); poke(1'b1, 8'h03, 16'h1234);
        poke(1'b1, 8'h04, 16'h0050); poke(1'b0, 8'h50, 16'h0000);
        pulse_start;
        check("rst_st_ill_cleared", {15'd0, illegal}, 16'd0);
        tick; tick;
        check("rst_st_we_before", {15'd0, mem_we}, 16'd1);
        reset = 1'b0;
        #1;
        check("rst_st_we_gated", {15'd0, mem_we}, 16'd0);
        tick;
        check("rst_st_mem50", mem[8'h50], 16'h0000);
        check("rst_st_pc", pc, 16'h0000);
        check("rst_st_busy", {15'd0, busy}, 16'd0);
        check("rst_st_idle_mode", {13'd0, alu_mode}, 16'd4);
        reset = 1'b1;
        tick;

        // Watchdog: ADD r0,r0 repeated, limit 4
        poke(1'b0, 8'h00, 16'h0000); poke(1'b0, 8'h01, 16'h0000);
        poke(1'b0, 8'h02, 16'h0000); poke(1'b0, 8'h03, 16'h0000);
        poke(1'b0, 8'h04, 16'h0000); poke(1'b0, 8'h05, 16'h0000);
        we_snap = we_count;
        pulse_start;
        wait_done("wd_done", 40);
        check("wd_timeout", {15'd0, timeout}, 16'd1);
        check("wd_count", instr_count, 16'd4);
        check("wd_pc", pc, 16'd4);
        check("wd_busy", {15'd0, busy}, 16'd0);
        check("wd_no_r0_we", we_count[15:0], we_snap[15:0]);
        tick;
        check("wd_done_pulse", {15'd0, done}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
